// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider behind a divisor/dividend stream handshake, with cancel.
// Optional build macro DIV_EARLY_OUT_EN: zero divisor or |dividend| < |divisor| finishes one edge after accept.
module div_iter_unit #(
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned WIDTH  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid,
  output logic               busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dq, dvs, dvd_raw;
  logic             q_neg, r_neg, dvs_zero, early;

  logic             ready, accept, last;
  logic             dvd_neg, dvs_neg, early_out;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted, diff, rem_nxt;
  logic             borrow;
  logic [WIDTH-1:0] q_step, rem_w, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] result;

  // Handshake: both operands must be valid in the same cycle while idle
  assign ready  = resetn && (state == IDLE) && !cancel;
  assign accept = ready && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
  assign s_axis_divisor_tready  = ready;
  assign s_axis_dividend_tready = ready;

  assign dvd_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
  assign dvs_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
  assign dvd_abs = dvd_neg ? (~s_axis_dividend_tdata + WIDTH'(1)) : s_axis_dividend_tdata;
  assign dvs_abs = dvs_neg ? (~s_axis_divisor_tdata + WIDTH'(1)) : s_axis_divisor_tdata;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (s_axis_divisor_tdata == '0) || (dvd_abs < dvs_abs);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, trial-subtract, restore on borrow
  assign shifted         = {rem, dq[WIDTH-1]};
  assign {borrow, diff}  = {1'b0, shifted} - {2'b00, dvs};
  assign rem_nxt         = borrow ? shifted : diff;
  assign rem_w           = WIDTH'(rem_nxt);
  assign q_step          = {dq[WIDTH-2:0], ~borrow};

  assign quo_fix = q_neg ? (~q_step + WIDTH'(1)) : q_step;
  assign rem_fix = r_neg ? (~rem_w + WIDTH'(1)) : rem_w;

  // Zero divisor overrides the arithmetic; early-out means quotient 0, remainder unchanged
  always_comb begin
    result = {quo_fix, rem_fix};
    if (dvs_zero) begin
      result = {{WIDTH{1'b1}}, dvd_raw};
    end else if (early) begin
      result = {{WIDTH{1'b0}}, dvd_raw};
    end
  end

  assign last = early || (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC: begin
        if (cancel)    state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt                <= '0;
      rem                <= '0;
      dq                 <= '0;
      dvs                <= '0;
      dvd_raw            <= '0;
      q_neg              <= 1'b0;
      r_neg              <= 1'b0;
      dvs_zero           <= 1'b0;
      early              <= 1'b0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
      busy               <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= (state_nxt == DONE);
      busy               <= (state_nxt != IDLE);
      if (accept) begin
        cnt      <= '0;
        rem      <= '0;
        dq       <= dvd_abs;
        dvs      <= dvs_abs;
        dvd_raw  <= s_axis_dividend_tdata;
        q_neg    <= dvd_neg ^ dvs_neg;
        r_neg    <= dvd_neg;
        dvs_zero <= (s_axis_divisor_tdata == '0);
        early    <= early_out;
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
        rem <= rem_w;
        dq  <= q_step;
        if (state_nxt == DONE) begin
          m_axis_dout_tdata <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: signed and unsigned instances share stimulus, checked against an arithmetic model.
module tb_div_iter_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn;
  logic           cancel;
  logic [W-1:0]   dvs_d, dvd_d;
  logic           dvs_v, dvd_v;

  logic           s_dvs_rdy, s_dvd_rdy, s_vld, s_busy;
  logic [2*W-1:0] s_data;
  logic           u_dvs_rdy, u_dvd_rdy, u_vld, u_busy;
  logic [2*W-1:0] u_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];

  div_iter_unit #(.SIGNED(1'b1), .WIDTH(W)) dut_s (
    .clk(clk), .resetn(resetn),
    .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(s_dvs_rdy),
    .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(s_dvd_rdy),
    .cancel(cancel),
    .m_axis_dout_tdata(s_data), .m_axis_dout_tvalid(s_vld), .busy(s_busy)
  );

  div_iter_unit #(.SIGNED(1'b0), .WIDTH(W)) dut_u (
    .clk(clk), .resetn(resetn),
    .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(u_dvs_rdy),
    .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(u_dvd_rdy),
    .cancel(cancel),
    .m_axis_dout_tdata(u_data), .m_axis_dout_tvalid(u_vld), .busy(u_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: C-style truncating division in 64-bit arithmetic, zero divisor special-cased
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  function automatic int lat_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? (32'd0 - a) : a;
    mb = (sgn && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0 || ma < mb) return 1;
`endif
    return 32;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (resetn === 1'b1 && s_vld === 1'b1) begin
      if (q_s.size() == 0) begin
        check("s_unexpected_valid", 64'(s_vld), 64'd0);
      end else begin
        e = q_s.pop_front();
        check("s_data", s_data, e.data);
        check("s_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : mon_u
    exp_t e;
    if (resetn === 1'b1 && u_vld === 1'b1) begin
      if (q_u.size() == 0) begin
        check("u_unexpected_valid", 64'(u_vld), 64'd0);
      end else begin
        e = q_u.pop_front();
        check("u_data", u_data, e.data);
        check("u_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Present both operands (at a negedge) and record the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push, input bit now);
    exp_t es, eu;
    if (!now) @(negedge clk);
    dvd_d = a; dvs_d = b; dvd_v = 1'b1; dvs_v = 1'b1;
    #1;
    check("ready_before_accept", 64'({s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}), 64'hF);
    @(posedge clk);
    #1;
    dvd_v = 1'b0; dvs_v = 1'b0;
    if (push) begin
      es.data = model(1'b1, a, b); es.acc = cyc; es.lat = lat_model(1'b1, a, b);
      eu.data = model(1'b0, a, b); eu.acc = cyc; eu.lat = lat_model(1'b0, a, b);
      q_s.push_back(es);
      q_u.push_back(eu);
    end
  endtask

  // Count cycles each unit holds tready low; returns at the negedge where both are ready
  task automatic wait_idle(input int exp_s, input int exp_u);
    int ns, nu, n;
    ns = 0; nu = 0; n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!s_dvs_rdy) ns++;
      if (!u_dvs_rdy) nu++;
      if (s_dvs_rdy && u_dvs_rdy) break;
      n++;
    end
    check("s_ready_low_cycles", 64'(ns), 64'(exp_s));
    check("u_ready_low_cycles", 64'(nu), 64'(exp_u));
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input bit now);
    issue(a, b, 1'b1, now);
    wait_idle(lat_model(1'b1, a, b) + 1, lat_model(1'b0, a, b) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int          kind;

    resetn = 1'b0; cancel = 1'b0;
    dvs_v = 1'b0; dvd_v = 1'b0; dvs_d = '0; dvd_d = '0;
    #12;
    check("reset_s_tvalid", 64'(s_vld), 64'd0);
    check("reset_s_tdata", s_data, 64'd0);
    check("reset_s_busy", 64'(s_busy), 64'd0);
    check("reset_tready", 64'({s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}), 64'd0);
    check("reset_u_tdata", u_data, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases
    op(32'd100, 32'd7, 1'b0);
    op(32'hFFFF_FFF9, 32'd2, 1'b0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    op(32'hFFFF_FFFF, 32'h10, 1'b0);
    op(32'd5, 32'd0, 1'b0);
    op(32'hFFFF_FFFB, 32'd0, 1'b0);
    op(32'd3, 32'd9, 1'b0);
    op(32'd9, 32'd3, 1'b1);

    // Dividend alone must not be accepted
    @(negedge clk);
    dvd_d = 32'd77; dvd_v = 1'b1; dvs_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_valid_busy", 64'({s_busy, u_busy}), 64'd0);
    end
    dvs_d = 32'd5;
    op(32'd77, 32'd5, 1'b1);

    // Cancel while the counter is at 10
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    #1 check("cancel_blocks_ready", 64'({s_dvs_rdy, u_dvs_rdy}), 64'd0);
    @(posedge clk);
    #1 cancel = 1'b0;
    #1 check("after_cancel_ready", 64'({s_dvs_rdy, u_dvs_rdy}), 64'h3);
    check("after_cancel_busy", 64'({s_busy, u_busy}), 64'd0);
    @(negedge clk);
    op(32'd9, 32'd3, 1'b1);

    // Asynchronous reset mid-calculation
    issue(32'd12345, 32'd7, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_tvalid", 64'({s_vld, u_vld}), 64'd0);
    check("midreset_s_tdata", s_data, 64'd0);
    check("midreset_u_tdata", u_data, 64'd0);
    check("midreset_busy", 64'({s_busy, u_busy}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Randomized operands, issued back-to-back in the cycle after each result
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 6));
      ra = $urandom;
      rb = $urandom;
      case (kind)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = 32'd0 - $urandom_range(1, 20);
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: ra = $urandom_range(0, 50);
        default: ;
      endcase
      op(ra, rb, 1'b1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(q_s.size() + q_u.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
